// File: rtl/wall_map_if.sv
// Bundle of the VGA read port and the game command port of the wall map.
// "master" drives requests/commands; "slave" is the wall map itself.
interface wall_map_if;
    logic       i_init;
    logic [5:0] i_request_x;
    logic [5:0] i_request_y;
    logic       i_buzy;
    logic       o_is_wall;
    logic       i_cmd_valid;
    logic [1:0] i_cmd_op;
    logic [5:0] i_cmd_x;
    logic [5:0] i_cmd_y;
    logic       o_cmd_ready;
    logic       o_cmd_done;
    logic       o_cmd_hit;
    logic       o_map_ready;

    modport master (
        output i_init, i_request_x, i_request_y, i_buzy,
        output i_cmd_valid, i_cmd_op, i_cmd_x, i_cmd_y,
        input  o_is_wall, o_cmd_ready, o_cmd_done, o_cmd_hit, o_map_ready
    );

    modport slave (
        input  i_init, i_request_x, i_request_y, i_buzy,
        input  i_cmd_valid, i_cmd_op, i_cmd_x, i_cmd_y,
        output o_is_wall, o_cmd_ready, o_cmd_done, o_cmd_hit, o_map_ready
    );
endinterface

// File: rtl/wall_map.sv
// Wall bitmap of the playfield: registered VGA read port plus a game command port
// (QUERY/CLEAR/SET) whose writes are held off while the renderer is in active lines.
module wall_map #(
    parameter int WIDTH       = 64,
    parameter int GAME_HEIGHT = 44
) (
    input  logic     clk,
    input  logic     rst_n,
    wall_map_if.slave bus
);
    localparam logic [5:0] LAST_ROW = 6'(GAME_HEIGHT - 1);
    localparam logic [5:0] NUM_ROWS = 6'(GAME_HEIGHT);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_QUERY = 2'b01;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_WAIT} state_t;

    state_t state, state_nxt;
    logic [5:0] row, row_nxt;
    logic [5:0] cmd_x, cmd_y;
    logic [1:0] cmd_op;
    logic       done, done_nxt;
    logic       hit, hit_nxt;
    logic       map_ready, map_ready_nxt;
    logic       is_wall;
    logic       accept;
    logic       do_write;
    logic       cmd_in_field;
    logic       old_cell;

    logic [GAME_HEIGHT-1:0][WIDTH-1:0] map_q;

    function automatic logic [WIDTH-1:0] row_pattern(input logic [5:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int x = 0; x < WIDTH; x++) begin
            r[x] = (x == 0) || (x == WIDTH - 1) || (y == 6'd0) || (y == LAST_ROW) ||
                   ((x % 8 == 4) && (y[2:0] == 3'd4));
        end
        return r;
    endfunction

    // Rows past the playfield behave as solid wall for both consumers.
    assign cmd_in_field = (cmd_y < NUM_ROWS);
    assign old_cell     = cmd_in_field ? map_q[cmd_y][cmd_x] : 1'b1;

    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        done_nxt      = 1'b0;
        hit_nxt       = hit;
        map_ready_nxt = map_ready;
        accept        = 1'b0;
        do_write      = 1'b0;
        case (state)
            S_INIT: begin
                row_nxt = row + 6'd1;
                if (row == LAST_ROW) begin
                    row_nxt       = '0;
                    map_ready_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    accept = 1'b1;
                    if (bus.i_cmd_op == OP_NOP) begin
                        done_nxt = 1'b1;
                        hit_nxt  = 1'b0;
                    end else if (bus.i_cmd_op == OP_QUERY || !bus.i_buzy) begin
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_EXEC, S_WAIT: begin
                if (state == S_EXEC || !bus.i_buzy) begin
                    done_nxt  = 1'b1;
                    hit_nxt   = old_cell;
                    do_write  = cmd_op[1] && cmd_in_field;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
        // A reload pre-empts everything, including an in-flight command.
        if (bus.i_init) begin
            state_nxt     = S_INIT;
            row_nxt       = '0;
            map_ready_nxt = 1'b0;
            done_nxt      = 1'b0;
            accept        = 1'b0;
            do_write      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            row       <= '0;
            cmd_x     <= '0;
            cmd_y     <= '0;
            cmd_op    <= '0;
            done      <= 1'b0;
            hit       <= 1'b0;
            map_ready <= 1'b0;
            is_wall   <= 1'b0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            done      <= done_nxt;
            hit       <= hit_nxt;
            map_ready <= map_ready_nxt;
            is_wall   <= (bus.i_request_y >= NUM_ROWS) ? 1'b1
                         : map_q[bus.i_request_y][bus.i_request_x];
            if (accept) begin
                cmd_x  <= bus.i_cmd_x;
                cmd_y  <= bus.i_cmd_y;
                cmd_op <= bus.i_cmd_op;
            end
        end
    end

    // Map contents are fully defined by the INIT sweep, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            map_q[row] <= row_pattern(row);
        else if (do_write)
            map_q[cmd_y][cmd_x] <= cmd_op[0];
    end

    assign bus.o_is_wall   = is_wall;
    assign bus.o_cmd_ready = (state == S_IDLE) && !bus.i_init;
    assign bus.o_cmd_done  = done;
    assign bus.o_cmd_hit   = hit;
    assign bus.o_map_ready = map_ready;
endmodule

// File: tb/tb_wall_map.sv
// Directed bench for wall_map: default map load, VGA reads, commands, deferred writes, reload.
module tb_wall_map;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    wall_map_if bus();

    wall_map #(.WIDTH(64), .GAME_HEIGHT(44)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic vga(input string tag, input logic [5:0] x, input logic [5:0] y, input logic exp);
        bus.i_request_x = x;
        bus.i_request_y = y;
        tick();
        chk(tag, bus.o_is_wall, exp);
    endtask

    // Issues one command from IDLE with i_buzy low and checks the done/hit timing.
    task automatic cmd(input string tag, input logic [1:0] op, input logic [5:0] x,
                       input logic [5:0] y, input logic exp_hit);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = op;
        bus.i_cmd_x     = x;
        bus.i_cmd_y     = y;
        chk({tag, "_ready"}, bus.o_cmd_ready, 1'b1);
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_x     = 6'd0;
        bus.i_cmd_y     = 6'd0;
        if (op != 2'b00) begin
            chk({tag, "_busy"}, bus.o_cmd_ready, 1'b0);
            chk({tag, "_nodone"}, bus.o_cmd_done, 1'b0);
            tick();
        end
        chk({tag, "_done"}, bus.o_cmd_done, 1'b1);
        chk({tag, "_hit"}, bus.o_cmd_hit, exp_hit);
        tick();
        chk({tag, "_pulse"}, bus.o_cmd_done, 1'b0);
    endtask

    task automatic wait_map_ready(input string tag);
        int k;
        k = 0;
        while (bus.o_map_ready !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk(tag, bus.o_map_ready, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n           = 1'b0;
        bus.i_init      = 1'b0;
        bus.i_request_x = 6'd0;
        bus.i_request_y = 6'd0;
        bus.i_buzy      = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 2'b00;
        bus.i_cmd_x     = 6'd0;
        bus.i_cmd_y     = 6'd0;
        tick();
        tick();
        chk("rst_is_wall", bus.o_is_wall, 1'b0);
        chk("rst_ready", bus.o_cmd_ready, 1'b0);
        chk("rst_done", bus.o_cmd_done, 1'b0);
        chk("rst_hit", bus.o_cmd_hit, 1'b0);
        chk("rst_map_ready", bus.o_map_ready, 1'b0);

        // 1. Load takes 44 edges; map_ready visible after the 44th.
        rst_n = 1'b1;
        for (int i = 1; i <= 43; i++) tick();
        chk("load_not_ready", bus.o_map_ready, 1'b0);
        chk("load_cmd_ready", bus.o_cmd_ready, 1'b0);
        tick();
        chk("load_ready", bus.o_map_ready, 1'b1);
        chk("idle_cmd_ready", bus.o_cmd_ready, 1'b1);
        vga("rd_0_5", 6'd0, 6'd5, 1'b1);
        vga("rd_4_4", 6'd4, 6'd4, 1'b1);
        vga("rd_5_5", 6'd5, 6'd5, 1'b0);
        vga("rd_12_20", 6'd12, 6'd20, 1'b1);
        vga("rd_63_43", 6'd63, 6'd43, 1'b1);
        vga("rd_30_0", 6'd30, 6'd0, 1'b1);
        vga("rd_30_1", 6'd30, 6'd1, 1'b0);

        // 2. Out-of-field rows read as wall; one-cycle latency.
        vga("rd_10_50", 6'd10, 6'd50, 1'b1);
        bus.i_request_x = 6'd10;
        bus.i_request_y = 6'd10;
        #1 chk("lat_hold", bus.o_is_wall, 1'b1);
        tick();
        chk("lat_10_10", bus.o_is_wall, 1'b0);

        // 3. Commands while not busy.
        cmd("set_10_10", 2'b11, 6'd10, 6'd10, 1'b0);
        cmd("qry_10_10", 2'b01, 6'd10, 6'd10, 1'b1);
        vga("rd_10_10_set", 6'd10, 6'd10, 1'b1);
        cmd("clr_4_4", 2'b10, 6'd4, 6'd4, 1'b1);
        vga("rd_4_4_clr", 6'd4, 6'd4, 1'b0);
        cmd("qry_4_4", 2'b01, 6'd4, 6'd4, 1'b0);
        cmd("nop", 2'b00, 6'd4, 6'd12, 1'b0);
        cmd("qry_out", 2'b01, 6'd5, 6'd50, 1'b1);
        cmd("clr_out", 2'b10, 6'd5, 6'd44, 1'b1);

        // 4. SET while busy is deferred until the first non-busy cycle.
        bus.i_buzy      = 1'b1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 2'b11;
        bus.i_cmd_x     = 6'd20;
        bus.i_cmd_y     = 6'd21;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 2'b10;
        bus.i_cmd_x     = 6'd0;
        bus.i_cmd_y     = 6'd0;
        for (int i = 0; i < 5; i++) begin
            chk("wait_ready", bus.o_cmd_ready, 1'b0);
            chk("wait_nodone", bus.o_cmd_done, 1'b0);
            bus.i_request_x = 6'd20;
            bus.i_request_y = 6'd21;
            tick();
        end
        chk("wait_rd_old", bus.o_is_wall, 1'b0);
        bus.i_buzy = 1'b0;
        tick();
        chk("blank_done", bus.o_cmd_done, 1'b1);
        chk("blank_hit", bus.o_cmd_hit, 1'b0);
        chk("blank_rd_same_edge", bus.o_is_wall, 1'b0);
        tick();
        chk("blank_pulse", bus.o_cmd_done, 1'b0);
        chk("blank_rd_new", bus.o_is_wall, 1'b1);

        // 5. Reload while a command waits for blanking: command is dropped.
        bus.i_buzy      = 1'b1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 2'b10;
        bus.i_cmd_x     = 6'd0;
        bus.i_cmd_y     = 6'd5;
        tick();
        bus.i_cmd_valid = 1'b0;
        tick();
        bus.i_init = 1'b1;
        tick();
        bus.i_init = 1'b0;
        bus.i_buzy = 1'b0;
        chk("reinit_map_low", bus.o_map_ready, 1'b0);
        for (int i = 1; i <= 43; i++) begin
            tick();
            chk("reinit_nodone", bus.o_cmd_done, 1'b0);
        end
        chk("reinit_still_low", bus.o_map_ready, 1'b0);
        tick();
        chk("reinit_ready", bus.o_map_ready, 1'b1);
        vga("reinit_rd_20_21", 6'd20, 6'd21, 1'b0);
        vga("reinit_rd_10_10", 6'd10, 6'd10, 1'b0);
        vga("reinit_rd_4_4", 6'd4, 6'd4, 1'b1);
        vga("reinit_rd_0_5", 6'd0, 6'd5, 1'b1);

        // i_init coinciding with a valid command: the command is never accepted.
        bus.i_init      = 1'b1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 2'b01;
        #1 chk("init_masks_ready", bus.o_cmd_ready, 1'b0);
        tick();
        bus.i_init      = 1'b0;
        bus.i_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("init_win_nodone", bus.o_cmd_done, 1'b0);
        end
        wait_map_ready("init_win_reload");

        // 6. Held-valid QUERY stream: one accept every other cycle.
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = 2'b01;
        bus.i_cmd_x     = 6'd4;
        bus.i_cmd_y     = 6'd4;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", bus.o_cmd_ready, (i % 2) == 0);
            chk("b2b_done", bus.o_cmd_done, (i % 2) == 0 && i > 0);
            if ((i % 2) == 0 && i > 0) chk("b2b_hit", bus.o_cmd_hit, 1'b1);
            tick();
        end
        bus.i_cmd_valid = 1'b0;
        chk("b2b_last_done", bus.o_cmd_done, 1'b1);
        tick();
        chk("b2b_quiet", bus.o_cmd_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
